// File: rtl/wb_write_queue_if.sv
// Writeback queue bus: ALU/load request ports, bank write port,
// and the hazard lookup used by decode.
interface wb_write_queue_if #(
    parameter int N     = 32,
    parameter int Bits  = 64,
    parameter int Depth = 4
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(Depth) + 1;

    logic            a_valid;
    logic [PW-1:0]   a_ptr;
    logic [Bits-1:0] a_data;
    logic            a_ready;
    logic            b_valid;
    logic [PW-1:0]   b_ptr;
    logic [Bits-1:0] b_data;
    logic            b_ready;
    logic            hold;
    logic [PW-1:0]   ptr_wr;
    logic [Bits-1:0] data_wr;
    logic            wr_en;
    logic [PW-1:0]   rs1_ptr;
    logic [PW-1:0]   rs2_ptr;
    logic            rs1_pending;
    logic            rs2_pending;
    logic [Bits-1:0] rs1_fwd;
    logic [Bits-1:0] rs2_fwd;
    logic [CW-1:0]   count;

    modport master (
        output a_valid, a_ptr, a_data,
        output b_valid, b_ptr, b_data,
        output hold, rs1_ptr, rs2_ptr,
        input  a_ready, b_ready,
        input  ptr_wr, data_wr, wr_en,
        input  rs1_pending, rs2_pending,
        input  rs1_fwd, rs2_fwd, count
    );

    modport slave (
        input  a_valid, a_ptr, a_data,
        input  b_valid, b_ptr, b_data,
        input  hold, rs1_ptr, rs2_ptr,
        output a_ready, b_ready,
        output ptr_wr, data_wr, wr_en,
        output rs1_pending, rs2_pending,
        output rs1_fwd, rs2_fwd, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order writeback FIFO in front of the register bank, with
// pending/forward lookup for two read pointers.
module wb_write_queue #(
    parameter int N     = 32,
    parameter int Bits  = 64,
    parameter int Depth = 4
) (
    input logic clk,
    input logic rst,
    wb_write_queue_if.slave bus
);
    localparam int PW = $clog2(N);
    localparam int AW = $clog2(Depth);
    localparam int CW = $clog2(Depth) + 1;

    logic [PW-1:0]   ptr_q  [Depth];
    logic [Bits-1:0] data_q [Depth];
    logic [AW-1:0]   head_q;
    logic [AW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    logic          pop;
    logic [CW-1:0] free;
    logic          b_take;
    logic          b_enq;
    logic          a_enq;
    logic [AW-1:0] a_slot;
    logic [CW-1:0] enq_n;

    assign pop  = (count_q != '0) && !bus.hold;
    assign free = CW'(Depth) - count_q + CW'(pop);

    assign bus.b_ready = !rst && (free >= CW'(1));
    assign b_take = bus.b_valid && bus.b_ready
                 && (bus.b_ptr != '0);
    assign bus.a_ready = !rst
                      && (free >= CW'(1) + CW'(b_take));

    // x0 requests are acknowledged but never occupy a slot.
    assign b_enq  = b_take;
    assign a_enq  = bus.a_valid && bus.a_ready
                 && (bus.a_ptr != '0);
    assign a_slot = tail_q + AW'(b_enq);
    assign enq_n  = CW'(b_enq) + CW'(a_enq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + AW'(pop);
            tail_q  <= tail_q + AW'(enq_n);
            count_q <= count_q + enq_n - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (b_enq) begin
            ptr_q[tail_q]  <= bus.b_ptr;
            data_q[tail_q] <= bus.b_data;
        end
        if (a_enq) begin
            ptr_q[a_slot]  <= bus.a_ptr;
            data_q[a_slot] <= bus.a_data;
        end
    end

    assign bus.wr_en   = pop;
    assign bus.ptr_wr  = pop ? ptr_q[head_q]  : '0;
    assign bus.data_wr = pop ? data_q[head_q] : '0;
    assign bus.count   = count_q;

    // Walk oldest to youngest so the last hit is the youngest entry.
    function automatic logic [Bits:0] find(
        input logic [PW-1:0] rs
    );
        logic [Bits:0] r;
        logic [AW-1:0] idx;
        r = '0;
        for (int k = 0; k < Depth; k++) begin
            idx = head_q + AW'(k);
            if (CW'(k) < count_q && rs != '0
                && ptr_q[idx] == rs) begin
                r = {1'b1, data_q[idx]};
            end
        end
        return r;
    endfunction

    logic [Bits:0] hit1;
    logic [Bits:0] hit2;

    assign hit1 = find(bus.rs1_ptr);
    assign hit2 = find(bus.rs2_ptr);

    assign bus.rs1_pending = hit1[Bits];
    assign bus.rs1_fwd     = hit1[Bits-1:0];
    assign bus.rs2_pending = hit2[Bits];
    assign bus.rs2_fwd     = hit2[Bits-1:0];
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: inputs change on the falling
// edge, outputs are checked 1ns later.
module tb_wb_write_queue;
    logic clk;
    logic rst;
    int   nvec;
    int   nmis;

    wb_write_queue_if #(.N(32), .Bits(64), .Depth(4)) bus ();

    wb_write_queue #(.N(32), .Bits(64), .Depth(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drv_a(input logic v, input logic [4:0] p,
                         input logic [63:0] d);
        bus.a_valid = v;
        bus.a_ptr   = p;
        bus.a_data  = d;
    endtask

    task automatic drv_b(input logic v, input logic [4:0] p,
                         input logic [63:0] d);
        bus.b_valid = v;
        bus.b_ptr   = p;
        bus.b_data  = d;
    endtask

    task automatic chk_wr(input string tag, input logic en,
                          input logic [4:0] p,
                          input logic [63:0] d);
        check({tag, ".wr_en"}, 64'(bus.wr_en), 64'(en));
        check({tag, ".ptr_wr"}, 64'(bus.ptr_wr), 64'(p));
        check({tag, ".data_wr"}, bus.data_wr, d);
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        rst = 1'b1;
        drv_a(1'b0, 5'd0, 64'h0);
        drv_b(1'b0, 5'd0, 64'h0);
        bus.hold    = 1'b0;
        bus.rs1_ptr = 5'd0;
        bus.rs2_ptr = 5'd0;

        // reset state
        step();
        step();
        #1;
        chk_wr("rst", 1'b0, 5'd0, 64'h0);
        check("rst.count", 64'(bus.count), 64'd0);
        check("rst.a_ready", 64'(bus.a_ready), 64'd0);
        check("rst.b_ready", 64'(bus.b_ready), 64'd0);
        check("rst.pend", 64'(bus.rs1_pending), 64'd0);
        check("rst.fwd", bus.rs1_fwd, 64'h0);

        // single write
        step(); rst = 1'b0;
        step(); drv_a(1'b1, 5'd5, 64'h1234); #1;
        check("sw.a_ready", 64'(bus.a_ready), 64'd1);
        chk_wr("sw.idle", 1'b0, 5'd0, 64'h0);
        step(); drv_a(1'b0, 5'd0, 64'h0); #1;
        chk_wr("sw.wr", 1'b1, 5'd5, 64'h1234);
        check("sw.count1", 64'(bus.count), 64'd1);
        step(); #1;
        check("sw.wr_en0", 64'(bus.wr_en), 64'd0);
        check("sw.count0", 64'(bus.count), 64'd0);

        // dual enqueue order
        step();
        drv_b(1'b1, 5'd3, 64'hBB);
        drv_a(1'b1, 5'd3, 64'hAA);
        bus.rs1_ptr = 5'd3;
        #1;
        check("du.b_ready", 64'(bus.b_ready), 64'd1);
        check("du.a_ready", 64'(bus.a_ready), 64'd1);
        check("du.pend_in", 64'(bus.rs1_pending), 64'd0);
        step();
        drv_b(1'b0, 5'd0, 64'h0);
        drv_a(1'b0, 5'd0, 64'h0);
        #1;
        check("du.count", 64'(bus.count), 64'd2);
        chk_wr("du.wr1", 1'b1, 5'd3, 64'hBB);
        check("du.pend", 64'(bus.rs1_pending), 64'd1);
        check("du.fwd", bus.rs1_fwd, 64'hAA);
        step(); #1;
        chk_wr("du.wr2", 1'b1, 5'd3, 64'hAA);
        check("du.fwd2", bus.rs1_fwd, 64'hAA);
        step(); #1;
        check("du.wr_en0", 64'(bus.wr_en), 64'd0);
        check("du.pend0", 64'(bus.rs1_pending), 64'd0);
        check("du.fwd0", bus.rs1_fwd, 64'h0);

        // x0 drop
        step(); drv_a(1'b1, 5'd0, 64'hFF); #1;
        check("x0.a_ready", 64'(bus.a_ready), 64'd1);
        step(); drv_a(1'b0, 5'd0, 64'h0); #1;
        check("x0.count", 64'(bus.count), 64'd0);
        check("x0.wr_en", 64'(bus.wr_en), 64'd0);
        step(); #1;
        check("x0.wr_en2", 64'(bus.wr_en), 64'd0);

        // full / hold / wrap
        step();
        bus.hold = 1'b1;
        drv_b(1'b1, 5'd1, 64'h10);
        drv_a(1'b1, 5'd2, 64'h20);
        #1;
        check("fh.rdy_b0", 64'(bus.b_ready), 64'd1);
        check("fh.rdy_a0", 64'(bus.a_ready), 64'd1);
        step();
        drv_b(1'b1, 5'd3, 64'h30);
        drv_a(1'b1, 5'd4, 64'h40);
        #1;
        check("fh.count2", 64'(bus.count), 64'd2);
        check("fh.wr_en_hold", 64'(bus.wr_en), 64'd0);
        check("fh.rdy_a1", 64'(bus.a_ready), 64'd1);
        step();
        drv_b(1'b0, 5'd0, 64'h0);
        drv_a(1'b1, 5'd6, 64'h60);
        bus.rs1_ptr = 5'd4;
        #1;
        check("fh.count4", 64'(bus.count), 64'd4);
        check("fh.a_ready", 64'(bus.a_ready), 64'd0);
        check("fh.b_ready", 64'(bus.b_ready), 64'd0);
        check("fh.wr_en", 64'(bus.wr_en), 64'd0);
        check("fh.fwd4", bus.rs1_fwd, 64'h40);
        step(); bus.hold = 1'b0; #1;
        chk_wr("fh.d1", 1'b1, 5'd1, 64'h10);
        check("fh.a_ready6", 64'(bus.a_ready), 64'd1);
        step(); drv_a(1'b0, 5'd0, 64'h0); #1;
        chk_wr("fh.d2", 1'b1, 5'd2, 64'h20);
        check("fh.count_k", 64'(bus.count), 64'd4);
        step(); #1;
        chk_wr("fh.d3", 1'b1, 5'd3, 64'h30);
        step(); #1;
        chk_wr("fh.d4", 1'b1, 5'd4, 64'h40);
        step(); #1;
        chk_wr("fh.d6", 1'b1, 5'd6, 64'h60);
        check("fh.count1", 64'(bus.count), 64'd1);
        step(); #1;
        check("fh.empty", 64'(bus.count), 64'd0);
        check("fh.wr_en0", 64'(bus.wr_en), 64'd0);

        // full with simultaneous pop
        step();
        bus.hold = 1'b1;
        drv_b(1'b1, 5'd11, 64'h110);
        drv_a(1'b1, 5'd12, 64'h120);
        step();
        drv_b(1'b1, 5'd13, 64'h130);
        drv_a(1'b1, 5'd14, 64'h140);
        step();
        bus.hold = 1'b0;
        drv_b(1'b1, 5'd9, 64'h90);
        drv_a(1'b1, 5'd10, 64'hA0);
        #1;
        check("fp.count", 64'(bus.count), 64'd4);
        check("fp.b_ready", 64'(bus.b_ready), 64'd1);
        check("fp.a_ready", 64'(bus.a_ready), 64'd0);
        chk_wr("fp.d11", 1'b1, 5'd11, 64'h110);
        step();
        bus.hold = 1'b1;
        drv_b(1'b0, 5'd0, 64'h0);
        drv_a(1'b0, 5'd0, 64'h0);
        bus.rs1_ptr = 5'd9;
        bus.rs2_ptr = 5'd10;
        #1;
        check("fp.count4", 64'(bus.count), 64'd4);
        check("fp.pend9", 64'(bus.rs1_pending), 64'd1);
        check("fp.fwd9", bus.rs1_fwd, 64'h90);
        check("fp.pend10", 64'(bus.rs2_pending), 64'd0);

        // async reset mid-stream
        step(); bus.hold = 1'b0; #1;
        chk_wr("ar.d12", 1'b1, 5'd12, 64'h120);
        step(); bus.rs1_ptr = 5'd14; #1;
        check("ar.count3", 64'(bus.count), 64'd3);
        chk_wr("ar.d13", 1'b1, 5'd13, 64'h130);
        check("ar.pend", 64'(bus.rs1_pending), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("ar.wr_en", 64'(bus.wr_en), 64'd0);
        check("ar.count", 64'(bus.count), 64'd0);
        check("ar.pend0", 64'(bus.rs1_pending), 64'd0);
        check("ar.fwd0", bus.rs1_fwd, 64'h0);
        check("ar.a_ready", 64'(bus.a_ready), 64'd0);
        step(); rst = 1'b0; #1;
        check("ar.post_cnt", 64'(bus.count), 64'd0);
        check("ar.post_wr", 64'(bus.wr_en), 64'd0);
        step(); drv_a(1'b1, 5'd7, 64'h77); #1;
        check("ar.a_ready7", 64'(bus.a_ready), 64'd1);
        check("ar.stale", 64'(bus.wr_en), 64'd0);
        step(); drv_a(1'b0, 5'd0, 64'h0); #1;
        chk_wr("ar.d7", 1'b1, 5'd7, 64'h77);
        check("ar.count1", 64'(bus.count), 64'd1);
        step(); #1;
        check("ar.end_wr", 64'(bus.wr_en), 64'd0);
        check("ar.end_cnt", 64'(bus.count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end
endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Initiator side of the register-bank write port: collects writeback requests from the ALU and load paths and buffers them in an in-order FIFO.
- Drains at most one entry per cycle onto the bank's ptr_wr/data_wr/wr_en inputs.
- Sits between the execute/memory stages and the register bank.
- Reports pending writes and the youngest pending data for both read pointers, so the decode stage can stall or forward.

Parameters:
- N, 32, number of architectural registers; pointer width is $clog2(N).
- Bits, 64, register data width.
- Depth, 4, FIFO entries (power of two, minimum 2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- a_valid  input  1  ALU writeback request.
- a_ptr  input  $clog2(N)  ALU destination register.
- a_data  input  Bits  ALU result.
- a_ready  output  1  ALU request accepted this cycle.
- b_valid  input  1  load writeback request.
- b_ptr  input  $clog2(N)  load destination register.
- b_data  input  Bits  load data.
- b_ready  output  1  load request accepted this cycle.
- hold  input  1  suppresses draining; entries are kept.
- ptr_wr  output  $clog2(N)  bank write pointer (head entry).
- data_wr  output  Bits  bank write data (head entry).
- wr_en  output  1  bank write enable.
- rs1_ptr, rs2_ptr  input  $clog2(N)  read pointers to check.
- rs1_pending, rs2_pending  output  1  a matching entry is queued.
- rs1_fwd, rs2_fwd  output  Bits  data of the youngest matching queued entry; 0 if none.
- count  output  $clog2(Depth)+1  occupied entries.

Behaviour:
- Reset (async, rst=1):
  - Head, tail and count clear to 0; all queued entries are discarded, including during a mid-stream reset.
  - wr_en=0, ptr_wr=0, data_wr=0, pending=0, fwd=0.
  - a_ready and b_ready are held 0 while rst=1.
- Pop:
  - pop = (count>0) && !hold.
  - wr_en = pop; ptr_wr and data_wr present the head entry (0 when wr_en=0). These are combinational from storage.
  - The head advances on the edge where pop=1. The bank has no backpressure.
- Free slots: free = Depth - count + pop.
- Acceptance (b has priority):
  - b_ready = (free >= 1).
  - a_ready = (free >= 1 + b_take), where b_take = b_valid && b_ready && (b_ptr != 0).
  - a_ready therefore depends combinationally on b_valid/b_ptr.
- Enqueue: on the edge, when both are taken, b is written at tail and a at tail+1. A lone request is written at tail.
- x0 writes: a request with ptr 0 is accepted per its ready rule but never enqueued, and consumes no slot.
- Count update: count_next = count + enq_count - pop, where enq_count is 0..2. Occupancy never exceeds Depth, and popping when empty is impossible.
- Latency: a request accepted at edge k can appear on wr_en no earlier than the cycle after edge k. With an empty queue and hold=0, it appears exactly then.
- Order: bank writes occur in acceptance order (b before a within a cycle). A later write to the same register overwrites the earlier one in the bank.
- Wrap-around: head and tail are modulo Depth; full (count=Depth) and empty (count=0) are distinguished only by count.
- Hazard lookup:
  - rsX_pending = 1 if any occupied entry has ptr == rsX_ptr and rsX_ptr != 0.
  - rsX_fwd = data of the youngest such entry (nearest tail).
  - Combinational from storage only; same-cycle incoming requests are not included.
  - The head entry being written this cycle still counts as pending.
- hold=1 with a full queue: a_ready = b_ready = 0; no pop; contents stable.
- hold=1 with a partially full queue: acceptance continues until full.

Test Plan:
- Single write: reset, then a_valid=1, a_ptr=5, a_data=0x1234 for one cycle.
  - Required: a_ready=1; next cycle wr_en=1, ptr_wr=5, data_wr=0x1234; following cycle wr_en=0, count=0.
- Dual enqueue order: same cycle b_ptr=3/0xBB and a_ptr=3/0xAA.
  - Required: both ready; consecutive bank writes 3←0xBB then 3←0xAA.
  - rs1_ptr=3 while both queued gives pending=1, fwd=0xAA.
- x0 drop: a_valid=1, a_ptr=0, a_data=0xFF.
  - Required: a_ready=1; count stays 0; wr_en never asserts.
- Full/hold/wrap:
  - hold=1; enqueue 4 entries (ptr 1..4, data 0x10..0x40).
  - Required: count=4, a_ready=b_ready=0.
  - Release hold with a_valid held (ptr 6): writes 1..4 drain in order, 6 is accepted as the first slot frees, and pointers wrap past index 3 correctly.
- Full with simultaneous pop: count=4, hold=0, b_valid and a_valid both non-x0.
  - Required: b_ready=1, a_ready=0; count stays 4.
- Async reset mid-stream: 3 entries queued; assert rst between edges.
  - Required: wr_en, count and pending drop to 0 immediately.
  - After release, no stale writes appear; a new write drains normally.
